cv32e40x_pma_sequencer: RTL and testbench
=========================================

// Module: cv32e40x_pma_sequencer
// PURPOSE
//  Sequences core transactions through the PMA check onto the OBI bus. Clean
//  transactions pass straight through. PMA-faulting ones are absorbed without
//  reaching the bus, and a PMA error response is injected in order, once all
//  earlier bus transactions have responded. Sits between the IF/LSU transaction
//  request and the OBI interface; the PMA block's outputs feed pma_*_i.
// PARAMETERS
//  MAX_OUTSTANDING  2  maximum bus transactions in flight (1..7)
//  CNT_W            $clog2(MAX_OUTSTANDING+1)  outstanding-counter width (derived, localparam)
// PORTS
//  clk                    in   1   clock
//  rst                    in   1   synchronous reset, active high
//  core_trans_valid_i     in   1   core request valid; addr/attrs stable until accepted
//  core_trans_ready_o     out  1   request accepted when valid&&ready
//  core_trans_addr_i      in   32  byte address
//  pma_err_i              in   1   PMA fault for core_trans_addr_i (combinational)
//  pma_bufferable_i       in   1   PMA bufferable attribute for core_trans_addr_i
//  bus_trans_valid_o      out  1   OBI request valid
//  bus_trans_ready_i      in   1   OBI grant
//  bus_trans_addr_o       out  32  = core_trans_addr_i
//  bus_trans_bufferable_o out  1   = pma_bufferable_i
//  bus_resp_valid_i       in   1   OBI response valid (in order)
//  bus_resp_err_i         in   1   OBI bus error
//  core_resp_valid_o      out  1   response to core
//  core_resp_err_o        out  1   bus error (passthrough)
//  core_resp_pma_err_o    out  1   injected PMA error response
// BEHAVIOUR
//  - State regs: fsm {IDLE, DRAIN, RESPOND}, cnt[CNT_W-1:0].
//  - Reset: fsm=IDLE, cnt=0. Pending injected response is discarded; no output is
//    registered, so all outputs are 0 whenever core_trans_valid_i=0 and bus_resp_valid_i=0.
//  - IDLE, pma_err_i=0:
//    - bus_trans_valid_o = core_trans_valid_i && (cnt<MAX_OUTSTANDING).
//    - core_trans_ready_o = bus_trans_valid_o && bus_trans_ready_i.
//    - Zero-latency passthrough.
//  - IDLE, pma_err_i=1, core_trans_valid_i=1:
//    - bus_trans_valid_o=0, core_trans_ready_o=1 (absorbed same cycle).
//    - next fsm = RESPOND if cnt_next==0, else DRAIN.
//  - DRAIN: core_trans_ready_o=0, bus_trans_valid_o=0; -> RESPOND when cnt_next==0.
//  - RESPOND (1 cycle): core_resp_valid_o=1, core_resp_pma_err_o=1, core_resp_err_o=0,
//    core_trans_ready_o=0; -> IDLE.
//  - Latency: injected response 1 cycle after absorption when nothing is outstanding.
//    Otherwise it comes 1 cycle after the last outstanding bus response.
//  - Counter:
//    - cnt_next = cnt + (bus_trans_valid_o&&bus_trans_ready_i) - bus_resp_valid_i.
//    - Simultaneous issue and response leave cnt unchanged.
//    - Full (cnt==MAX_OUTSTANDING) blocks issue even if a response arrives that cycle.
//    - Never wraps; assertions: no increment at MAX, no decrement at 0.
//  - Bus responses: core_resp_valid_o=bus_resp_valid_i, core_resp_err_o=bus_resp_err_i,
//    core_resp_pma_err_o=0, in all states except RESPOND.
//  - bus_resp_valid_i in RESPOND is a protocol violation (cnt==0); assertion fires.
//  - OBI stability: once bus_trans_valid_o=1 it holds until granted. This relies on
//    the core holding the address. pma_err_i is a pure function of the address.
// TESTING
//  - Reset: rst=1 for 2 cycles, valid=1 -> ready=0, bus valid=0; fsm=IDLE, cnt=0 after release.
//  - Passthrough: addr=0x0000_1000, pma_err=0, ready_i=1 -> bus valid same cycle,
//    cnt=1; resp(err=1) -> core_resp_err_o=1, cnt=0.
//  - Full: MAX=2, two grants with no response -> 3rd request has bus valid=0 and
//    ready=0 until a response arrives.
//  - Isolated PMA fault: cnt=0, pma_err=1 at cycle N -> ready=1 at N, bus valid=0,
//    core_resp_pma_err_o=1 at N+1 only.
//  - Ordered fault: cnt=2, fault absorbed at N, bus responses at N+3 and N+5 ->
//    injected response at N+6; no core request accepted N+1..N+6.
//  - Reset mid-DRAIN: rst at N+2 -> no injected response, cnt=0, next clean request passes.

Source files
------------

// File: rtl/cv32e40x_pma_sequencer.sv
// PMA sequencer: passes clean core transactions onto OBI, absorbs PMA-faulting ones
// and injects their error response in order behind earlier bus responses.

module cv32e40x_pma_sequencer_chk #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned CNT_W           = 2
) (
    input logic             clk,
    input logic             rst,
    input logic [CNT_W-1:0] cnt_i,
    input logic             issue_i,
    input logic             resp_i,
    input logic             respond_i
);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // Counter never wraps and no bus response may coincide with the injected slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(issue_i && (cnt_i == MAX_CNT)));
            assert (!(resp_i && (cnt_i == CNT_ZERO)));
            assert (!(resp_i && respond_i));
        end
    end
endmodule

module cv32e40x_pma_sequencer #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_trans_valid_i,
    output logic        core_trans_ready_o,
    input  logic [31:0] core_trans_addr_i,
    input  logic        pma_err_i,
    input  logic        pma_bufferable_i,
    output logic        bus_trans_valid_o,
    input  logic        bus_trans_ready_i,
    output logic [31:0] bus_trans_addr_o,
    output logic        bus_trans_bufferable_o,
    input  logic        bus_resp_valid_i,
    input  logic        bus_resp_err_i,
    output logic        core_resp_valid_o,
    output logic        core_resp_err_o,
    output logic        core_resp_pma_err_o
);
    localparam int unsigned      CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        RESPOND = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             issue_s;
    logic             inc_s;
    logic             dec_s;

    assign bus_trans_addr_o       = core_trans_addr_i;
    assign bus_trans_bufferable_o = pma_bufferable_i;

    // Handshake outputs, outstanding-count update and next-state selection.
    always_comb begin
        state_d             = state_q;
        bus_trans_valid_o   = 1'b0;
        core_trans_ready_o  = 1'b0;
        core_resp_valid_o   = 1'b0;
        core_resp_err_o     = 1'b0;
        core_resp_pma_err_o = 1'b0;
        if (rst) begin
            state_d = IDLE;
        end else begin
            core_resp_valid_o = bus_resp_valid_i;
            core_resp_err_o   = bus_resp_err_i;
            case (state_q)
                IDLE: begin
                    if (core_trans_valid_i && pma_err_i) begin
                        core_trans_ready_o = 1'b1;
                    end else begin
                        bus_trans_valid_o  = core_trans_valid_i && (cnt_q < MAX_CNT);
                        core_trans_ready_o = bus_trans_valid_o && bus_trans_ready_i;
                    end
                end
                DRAIN: begin
                    core_trans_ready_o = 1'b0;
                end
                RESPOND: begin
                    core_resp_valid_o   = 1'b1;
                    core_resp_err_o     = 1'b0;
                    core_resp_pma_err_o = 1'b1;
                end
                default: begin
                    core_resp_valid_o = 1'b0;
                    core_resp_err_o   = 1'b0;
                end
            endcase
        end

        issue_s = bus_trans_valid_o && bus_trans_ready_i;
        // Saturating guards keep the counter in range even under a protocol violation.
        inc_s   = issue_s && (cnt_q != MAX_CNT);
        dec_s   = bus_resp_valid_i && (cnt_q != CNT_ZERO) && (state_q != RESPOND);
        cnt_d   = cnt_q + CNT_W'(inc_s) - CNT_W'(dec_s);

        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (core_trans_valid_i && pma_err_i) begin
                        state_d = (cnt_d == CNT_ZERO) ? RESPOND : DRAIN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DRAIN: begin
                    state_d = (cnt_d == CNT_ZERO) ? RESPOND : DRAIN;
                end
                RESPOND: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = IDLE;
        end
    end

    // State and outstanding-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    cv32e40x_pma_sequencer_chk #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .cnt_i     (cnt_q),
        .issue_i   (issue_s),
        .resp_i    (bus_resp_valid_i),
        .respond_i (state_q == RESPOND)
    );
endmodule

// File: tb/tb_cv32e40x_pma_sequencer.sv
// Bench for cv32e40x_pma_sequencer: directed cycle table followed by random traffic
// checked against a transaction-level model.

module tb_cv32e40x_pma_sequencer;
    localparam int MAX = 2;

    logic        clk;
    logic        rst;
    logic        core_trans_valid_i;
    logic        core_trans_ready_o;
    logic [31:0] core_trans_addr_i;
    logic        pma_err_i;
    logic        pma_bufferable_i;
    logic        bus_trans_valid_o;
    logic        bus_trans_ready_i;
    logic [31:0] bus_trans_addr_o;
    logic        bus_trans_bufferable_o;
    logic        bus_resp_valid_i;
    logic        bus_resp_err_i;
    logic        core_resp_valid_o;
    logic        core_resp_err_o;
    logic        core_resp_pma_err_o;

    // Address map: top nibble F faults, bit 4 marks bufferable.
    assign pma_err_i        = (core_trans_addr_i[31:28] == 4'hF);
    assign pma_bufferable_i = core_trans_addr_i[4];

    cv32e40x_pma_sequencer #(.MAX_OUTSTANDING(MAX)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .core_trans_valid_i     (core_trans_valid_i),
        .core_trans_ready_o     (core_trans_ready_o),
        .core_trans_addr_i      (core_trans_addr_i),
        .pma_err_i              (pma_err_i),
        .pma_bufferable_i       (pma_bufferable_i),
        .bus_trans_valid_o      (bus_trans_valid_o),
        .bus_trans_ready_i      (bus_trans_ready_i),
        .bus_trans_addr_o       (bus_trans_addr_o),
        .bus_trans_bufferable_o (bus_trans_bufferable_o),
        .bus_resp_valid_i       (bus_resp_valid_i),
        .bus_resp_err_i         (bus_resp_err_i),
        .core_resp_valid_o      (core_resp_valid_o),
        .core_resp_err_o        (core_resp_err_o),
        .core_resp_pma_err_o    (core_resp_pma_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v;
        logic [31:0] addr;
        logic        gnt;
        logic        rv;
        logic        re;
        logic [4:0]  exp;   // {ready, bus_valid, resp_valid, resp_err, pma_err}
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Transaction-level model state.
    int m_out;
    bit m_wait;
    bit m_inject;

    task automatic add(input logic r, input logic v, input logic [31:0] a,
                       input logic g, input logic rv, input logic re, input logic [4:0] e);
        vec_t t;
        t.rst = r; t.v = v; t.addr = a; t.gnt = g; t.rv = rv; t.re = re; t.exp = e;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [31:0] a,
                         input logic g, input logic rv, input logic re);
        rst = r; core_trans_valid_i = v; core_trans_addr_i = a;
        bus_trans_ready_i = g; bus_resp_valid_i = rv; bus_resp_err_i = re;
    endtask

    task automatic check_outs(input string tag, input logic [4:0] e);
        chk({tag, ".ready"},      {31'd0, core_trans_ready_o},  {31'd0, e[4]});
        chk({tag, ".bus_valid"},  {31'd0, bus_trans_valid_o},   {31'd0, e[3]});
        chk({tag, ".resp_valid"}, {31'd0, core_resp_valid_o},   {31'd0, e[2]});
        chk({tag, ".resp_err"},   {31'd0, core_resp_err_o},     {31'd0, e[1]});
        chk({tag, ".pma_err"},    {31'd0, core_resp_pma_err_o}, {31'd0, e[0]});
        chk({tag, ".bus_addr"},   bus_trans_addr_o,             core_trans_addr_i);
        chk({tag, ".bufferable"}, {31'd0, bus_trans_bufferable_o}, {31'd0, core_trans_addr_i[4]});
    endtask

    // Expected outputs for this cycle's inputs, then advance the model by one cycle.
    task automatic model(input logic r, input logic v, input logic perr, input logic g,
                         input logic rv, input logic re, output logic [4:0] e);
        logic rdy, bv;
        rdy = 1'b0; bv = 1'b0;
        e = 5'b00000;
        if (r) begin
            m_out = 0; m_wait = 1'b0; m_inject = 1'b0;
        end else if (m_inject) begin
            e = 5'b00101;
            m_inject = 1'b0;
        end else if (m_wait || (v && perr)) begin
            rdy = !m_wait;
            if (rv) m_out = m_out - 1;
            if (m_out == 0) begin
                m_inject = 1'b1; m_wait = 1'b0;
            end else begin
                m_wait = 1'b1;
            end
            e = {rdy, 1'b0, rv, re, 1'b0};
        end else begin
            bv  = v && (m_out < MAX);
            rdy = bv && g;
            m_out = m_out + int'(rdy) - int'(rv);
            e = {rdy, bv, rv, re, 1'b0};
        end
    endtask

    localparam logic [31:0] C0 = 32'h0000_1000;
    localparam logic [31:0] C1 = 32'h0000_1010;
    localparam logic [31:0] C2 = 32'h0000_1020;
    localparam logic [31:0] C3 = 32'h0000_1030;
    localparam logic [31:0] FA = 32'hF000_0000;

    initial begin
        logic [4:0]  e;
        logic        hold, v, g, rv, re, r;
        logic [31:0] a;

        drive(1'b1, 1'b1, C0, 1'b1, 1'b0, 1'b0);

        // Reset held two cycles with a request pending.
        add(1'b1, 1'b1, C0, 1'b1, 1'b0, 1'b0, 5'b00000);
        add(1'b1, 1'b1, C0, 1'b1, 1'b0, 1'b0, 5'b00000);
        add(1'b0, 1'b0, C0, 1'b0, 1'b0, 1'b0, 5'b00000);
        // Passthrough then bus error response.
        add(1'b0, 1'b1, C0, 1'b1, 1'b0, 1'b0, 5'b11000);
        add(1'b0, 1'b0, C0, 1'b0, 1'b1, 1'b1, 5'b00110);
        // Fill to MAX; third request blocked, even alongside a response.
        add(1'b0, 1'b1, C1, 1'b0, 1'b0, 1'b0, 5'b01000);
        add(1'b0, 1'b1, C1, 1'b1, 1'b0, 1'b0, 5'b11000);
        add(1'b0, 1'b1, C2, 1'b1, 1'b0, 1'b0, 5'b11000);
        add(1'b0, 1'b1, C3, 1'b1, 1'b0, 1'b0, 5'b00000);
        add(1'b0, 1'b1, C3, 1'b1, 1'b1, 1'b0, 5'b00100);
        add(1'b0, 1'b1, C3, 1'b1, 1'b0, 1'b0, 5'b11000);
        // Ordered fault at N with two outstanding; responses at N+3, N+5; injection N+6.
        add(1'b0, 1'b1, FA, 1'b1, 1'b0, 1'b0, 5'b10000);
        add(1'b0, 1'b1, C0, 1'b1, 1'b0, 1'b0, 5'b00000);
        add(1'b0, 1'b1, C0, 1'b1, 1'b0, 1'b0, 5'b00000);
        add(1'b0, 1'b1, C0, 1'b1, 1'b1, 1'b0, 5'b00100);
        add(1'b0, 1'b1, C0, 1'b1, 1'b0, 1'b0, 5'b00000);
        add(1'b0, 1'b1, C0, 1'b1, 1'b1, 1'b1, 5'b00110);
        add(1'b0, 1'b1, C0, 1'b1, 1'b0, 1'b0, 5'b00101);
        add(1'b0, 1'b1, C0, 1'b1, 1'b0, 1'b0, 5'b11000);
        add(1'b0, 1'b0, C0, 1'b0, 1'b1, 1'b0, 5'b00100);
        // Isolated fault: injected response exactly one cycle later.
        add(1'b0, 1'b1, FA, 1'b1, 1'b0, 1'b0, 5'b10000);
        add(1'b0, 1'b0, C0, 1'b0, 1'b0, 1'b0, 5'b00101);
        add(1'b0, 1'b0, C0, 1'b0, 1'b0, 1'b0, 5'b00000);
        // Reset while draining discards the injection and clears the counter.
        add(1'b0, 1'b1, C0, 1'b1, 1'b0, 1'b0, 5'b11000);
        add(1'b0, 1'b1, FA, 1'b1, 1'b0, 1'b0, 5'b10000);
        add(1'b0, 1'b0, C0, 1'b0, 1'b0, 1'b0, 5'b00000);
        add(1'b1, 1'b1, C0, 1'b1, 1'b0, 1'b0, 5'b00000);
        add(1'b0, 1'b0, C0, 1'b0, 1'b0, 1'b0, 5'b00000);
        add(1'b0, 1'b1, C0, 1'b1, 1'b0, 1'b0, 5'b11000);
        add(1'b0, 1'b1, C1, 1'b1, 1'b0, 1'b0, 5'b11000);
        add(1'b0, 1'b1, C2, 1'b1, 1'b0, 1'b0, 5'b00000);
        add(1'b0, 1'b0, C2, 1'b0, 1'b1, 1'b0, 5'b00100);
        add(1'b0, 1'b0, C2, 1'b0, 1'b1, 1'b0, 5'b00100);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].addr, vecs[i].gnt, vecs[i].rv, vecs[i].re);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].exp);
            @(posedge clk);
            #1;
        end

        // Random phase: protocol-respecting traffic against the model.
        drive(1'b1, 1'b0, C0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        m_out = 0; m_wait = 1'b0; m_inject = 1'b0;
        hold = 1'b0; v = 1'b0; a = C0;
        for (int c = 0; c < 2000; c++) begin
            r = ($urandom_range(0, 59) == 0);
            if (!hold) begin
                v = ($urandom_range(0, 2) != 0);
                a = $urandom;
                if ($urandom_range(0, 3) == 0) a[31:28] = 4'hF;
                else if (a[31:28] == 4'hF) a[31:28] = 4'h0;
            end
            g  = $urandom_range(0, 1);
            rv = (m_out > 0) && !m_inject && ($urandom_range(0, 1) == 1);
            re = rv && ($urandom_range(0, 1) == 1);
            drive(r, v, a, g, rv, re);
            #1;
            model(r, v, (a[31:28] == 4'hF), g, rv, re, e);
            check_outs($sformatf("rnd%0d", c), e);
            hold = v && !e[4] && !r;
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
